// File: rtl/wts_channel_writer.sv
// Write side of the wave table channel selector. A 2-entry in-order queue feeds
// five channel registers. The time-slot counter blocks commits to the active channel.
module wts_channel_writer #(
  parameter int bits = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            slot_en,
  output logic [2:0]      active,
  input  logic            wr,
  input  logic [2:0]      wr_ch,
  input  logic [bits-1:0] wr_data,
  output logic            wr_ready,
  output logic            pending,
  output logic [bits-1:0] reg_a,
  output logic [bits-1:0] reg_b,
  output logic [bits-1:0] reg_c,
  output logic [bits-1:0] reg_d,
  output logic [bits-1:0] reg_e
);

  logic [2:0]      active_q, active_d;
  logic [1:0]      count_q, count_d;
  logic [2:0]      ch0_q, ch0_d, ch1_q, ch1_d;
  logic [bits-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
  logic [bits-1:0] regs_q [5];
  logic [bits-1:0] regs_d [5];
  logic            push, pop;
  logic [1:0]      tail_idx;

  assign wr_ready = (count_q != 2'd2);
  assign pending  = (count_q != 2'd0);
  assign active   = active_q;
  assign reg_a    = regs_q[0];
  assign reg_b    = regs_q[1];
  assign reg_c    = regs_q[2];
  assign reg_d    = regs_q[3];
  assign reg_e    = regs_q[4];

  // Slot counter: wraps 4 -> 0 so codes 5..7 never appear.
  always_comb begin
    active_d = active_q;
    if (slot_en) begin
      if (active_q == 3'd4) begin
        active_d = 3'd0;
      end else begin
        active_d = active_q + 3'd1;
      end
    end else begin
      active_d = active_q;
    end
  end

  // Queue control. Commit uses the pre-update slot; the pop frees index 0 before
  // the push picks its tail slot, so a new entry can never commit on arrival.
  always_comb begin
    pop      = (count_q != 2'd0) && (ch0_q != active_q);
    push     = wr && wr_ready && (wr_ch < 3'd5);
    tail_idx = count_q - {1'b0, pop};
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    ch0_d    = ch0_q;
    dat0_d   = dat0_q;
    ch1_d    = ch1_q;
    dat1_d   = dat1_q;
    if (pop) begin
      ch0_d  = ch1_q;
      dat0_d = dat1_q;
    end else begin
      ch0_d  = ch0_q;
      dat0_d = dat0_q;
    end
    if (push) begin
      if (tail_idx == 2'd0) begin
        ch0_d  = wr_ch;
        dat0_d = wr_data;
      end else begin
        ch1_d  = wr_ch;
        dat1_d = wr_data;
      end
    end else begin
      ch1_d  = ch1_q;
      dat1_d = dat1_q;
    end
  end

  // Channel register load from the committed head entry.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (pop) begin
      case (ch0_q)
        3'd0:    regs_d[0] = dat0_q;
        3'd1:    regs_d[1] = dat0_q;
        3'd2:    regs_d[2] = dat0_q;
        3'd3:    regs_d[3] = dat0_q;
        3'd4:    regs_d[4] = dat0_q;
        default: regs_d[0] = regs_q[0];
      endcase
    end else begin
      regs_d[0] = regs_q[0];
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 3'd0;
      count_q  <= 2'd0;
      ch0_q    <= 3'd0;
      ch1_q    <= 3'd0;
      dat0_q   <= '0;
      dat1_q   <= '0;
      for (int i = 0; i < 5; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      active_q <= active_d;
      count_q  <= count_d;
      ch0_q    <= ch0_d;
      ch1_q    <= ch1_d;
      dat0_q   <= dat0_d;
      dat1_q   <= dat1_d;
      for (int i = 0; i < 5; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_wts_channel_writer.sv
// Randomized and directed bench for wts_channel_writer; a queue-based reference model
// predicts the post-edge state, and a separate monitor compares it every cycle.
module tb_wts_channel_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       slot_en = 1'b0;
  logic       wr = 1'b0;
  logic [2:0] wr_ch = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic [2:0] active;
  logic       wr_ready, pending;
  logic [7:0] reg_a, reg_b, reg_c, reg_d, reg_e;

  wts_channel_writer #(.bits(8)) dut (
    .clk(clk), .reset(reset), .slot_en(slot_en), .active(active),
    .wr(wr), .wr_ch(wr_ch), .wr_data(wr_data), .wr_ready(wr_ready),
    .pending(pending), .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c),
    .reg_d(reg_d), .reg_e(reg_e)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
  } entry_t;

  typedef struct packed {
    logic [2:0]      act;
    logic [4:0][7:0] regs;
    logic            pend;
    logic            rdy;
  } exp_t;

  exp_t   sb [$];
  entry_t m_q [$];
  int     m_active;
  logic [4:0][7:0] m_regs;
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.act  = 3'(m_active);
    e.regs = m_regs;
    e.pend = (m_q.size() != 0);
    e.rdy  = (m_q.size() < 2);
    return e;
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_regs   = '0;
    m_q.delete();
  endtask

  // One clock edge of the behaviour: commit the head if its channel is not the
  // current slot, accept a valid write if there was room, then advance the slot.
  task automatic model_step(input logic se, input logic w, input logic [2:0] ch, input logic [7:0] d);
    entry_t ne;
    bit room;
    room = (m_q.size() < 2);
    if (m_q.size() > 0 && int'(m_q[0].ch) != m_active) begin
      m_regs[m_q[0].ch] = m_q[0].data;
      void'(m_q.pop_front());
    end
    if (w && room && ch < 3'd5) begin
      ne.ch = ch;
      ne.data = d;
      m_q.push_back(ne);
    end
    if (se) m_active = (m_active + 1) % 5;
  endtask

  task automatic cycle(input logic r, input logic se, input logic w,
                       input logic [2:0] ch, input logic [7:0] d);
    @(negedge clk);
    reset = r; slot_en = se; wr = w; wr_ch = ch; wr_data = d;
    if (r) begin
      model_reset();
      #1;
      chk("rst_active", int'(active), 0);
      chk("rst_regs", int'({reg_a, reg_b, reg_c, reg_d, reg_e}), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_wr_ready", int'(wr_ready), 1);
    end else begin
      model_step(se, w, ch, d);
    end
    sb.push_back(snap());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
  endtask

  task automatic goto_slot(input int s);
    for (int i = 0; i < 5 && m_active != s; i++) cycle(1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
  endtask

  // Monitor: compares the DUT state after every rising edge with the model prediction.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("active", int'(active), int'(e.act));
      chk("reg_a", int'(reg_a), int'(e.regs[0]));
      chk("reg_b", int'(reg_b), int'(e.regs[1]));
      chk("reg_c", int'(reg_c), int'(e.regs[2]));
      chk("reg_d", int'(reg_d), int'(e.regs[3]));
      chk("reg_e", int'(reg_e), int'(e.regs[4]));
      chk("pending", int'(pending), int'(e.pend));
      chk("wr_ready", int'(wr_ready), int'(e.rdy));
    end
  end

  initial begin
    model_reset();
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    // basic write with active = 0
    cycle(1'b0, 1'b0, 1'b1, 3'd2, 8'h5A);
    idle(3);
    // active-slot stall plus a third write into a full queue
    goto_slot(3);
    cycle(1'b0, 1'b0, 1'b1, 3'd3, 8'h11);
    cycle(1'b0, 1'b0, 1'b1, 3'd1, 8'h22);
    cycle(1'b0, 1'b0, 1'b1, 3'd0, 8'h33);
    idle(3);
    cycle(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
    idle(4);
    // invalid channels, then reg_e at slot 0
    cycle(1'b0, 1'b0, 1'b1, 3'd5, 8'hA5);
    cycle(1'b0, 1'b0, 1'b1, 3'd6, 8'hA6);
    cycle(1'b0, 1'b0, 1'b1, 3'd7, 8'hA7);
    goto_slot(0);
    cycle(1'b0, 1'b0, 1'b1, 3'd4, 8'hFF);
    idle(3);
    // same channel ordering
    goto_slot(1);
    cycle(1'b0, 1'b0, 1'b1, 3'd0, 8'h01);
    cycle(1'b0, 1'b0, 1'b1, 3'd0, 8'h02);
    idle(3);
    // slot_en on every cycle with wrap
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1, 3'(i % 5), 8'(8'h40 + i));
    idle(4);
    // mid-run reset with two entries queued, then seven slot strobes
    cycle(1'b0, 1'b0, 1'b1, 3'(m_active), 8'hAA);
    cycle(1'b0, 1'b0, 1'b1, 3'(m_active), 8'hBB);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)), 8'($urandom));
    end
    idle(3);
    @(negedge clk);
    #20;
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
